fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage of the single-cycle core.
// It fetches one instruction, holds it for one EXEC cycle, and then selects the next PC
// from AddrSelector and the ALU compare flags.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [4:0]         HALT_OP  = 5'b11111
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imemReqOut,
    output logic [ADDR_W-1:0] imemAddrOut,
    input  logic              imemValidIn,
    input  logic [31:0]       imemDataIn,
    output logic [31:0]       instrOut,
    output logic [4:0]        opcodeOut,
    output logic              instrValidOut,
    input  logic [2:0]        addrSelIn,
    input  logic              ltFlagIn,
    input  logic              eqFlagIn,
    input  logic [ADDR_W-1:0] immIn,
    input  logic [ADDR_W-1:0] jalrBaseIn,
    output logic [ADDR_W-1:0] pcOut,
    output logic [ADDR_W-1:0] linkAddrOut,
    output logic              haltOut,
    output logic [31:0]       retireCountOut
);

    localparam int unsigned CNT_W = 32;

    localparam logic [2:0] SEL_SEQ  = 3'b000;
    localparam logic [2:0] SEL_BLT  = 3'b001;
    localparam logic [2:0] SEL_BEQ  = 3'b010;
    localparam logic [2:0] SEL_JAL  = 3'b011;
    localparam logic [2:0] SEL_JALR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] jalr_tgt;
    logic [ADDR_W-1:0] next_pc;

    // Outputs that are direct views of registered state
    assign pcOut       = pc;
    assign imemAddrOut = pc;
    assign opcodeOut   = instrOut[31:27];

    // Next-PC selection from AddrSelector and flags; all sums wrap at ADDR_W bits
    always_comb begin
        pc_inc   = ADDR_W'(pc + ADDR_W'(1));
        pc_rel   = ADDR_W'(pc + immIn);
        jalr_tgt = ADDR_W'(jalrBaseIn + immIn);
        next_pc  = pc_inc;
        case (addrSelIn)
            SEL_SEQ:  next_pc = pc_inc;
            SEL_BLT:  next_pc = ltFlagIn ? pc_rel : pc_inc;
            SEL_BEQ:  next_pc = eqFlagIn ? pc_rel : pc_inc;
            SEL_JAL:  next_pc = pc_rel;
            SEL_JALR: next_pc = jalr_tgt;
            default:  next_pc = pc_inc;
        endcase
    end

    // Fetch/execute sequencer with registered handshake, status and PC state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            linkAddrOut    <= ADDR_W'(RESET_PC + ADDR_W'(1));
            instrOut       <= '0;
            imemReqOut     <= 1'b0;
            instrValidOut  <= 1'b0;
            haltOut        <= 1'b0;
            retireCountOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    imemReqOut <= 1'b1;
                end
                FETCH: begin
                    if (imemValidIn) begin
                        instrOut      <= imemDataIn;
                        state         <= EXEC;
                        imemReqOut    <= 1'b0;
                        instrValidOut <= 1'b1;
                    end
                end
                EXEC: begin
                    instrValidOut <= 1'b0;
                    if (retireCountOut != {CNT_W{1'b1}}) begin
                        retireCountOut <= CNT_W'(retireCountOut + CNT_W'(1));
                    end
                    if (instrOut[31:27] == HALT_OP) begin
                        state   <= HALT;
                        haltOut <= 1'b1;
                    end else begin
                        pc          <= next_pc;
                        linkAddrOut <= ADDR_W'(next_pc + ADDR_W'(1));
                        state       <= FETCH;
                        imemReqOut  <= 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors, multi-cycle corner sequences and random instruction
// streams checked against an instruction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imemReqOut;
    logic [15:0] imemAddrOut;
    logic        imemValidIn;
    logic [31:0] imemDataIn;
    logic [31:0] instrOut;
    logic [4:0]  opcodeOut;
    logic        instrValidOut;
    logic [2:0]  addrSelIn;
    logic        ltFlagIn;
    logic        eqFlagIn;
    logic [15:0] immIn;
    logic [15:0] jalrBaseIn;
    logic [15:0] pcOut;
    logic [15:0] linkAddrOut;
    logic        haltOut;
    logic [31:0] retireCountOut;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imemReqOut     (imemReqOut),
        .imemAddrOut    (imemAddrOut),
        .imemValidIn    (imemValidIn),
        .imemDataIn     (imemDataIn),
        .instrOut       (instrOut),
        .opcodeOut      (opcodeOut),
        .instrValidOut  (instrValidOut),
        .addrSelIn      (addrSelIn),
        .ltFlagIn       (ltFlagIn),
        .eqFlagIn       (eqFlagIn),
        .immIn          (immIn),
        .jalrBaseIn     (jalrBaseIn),
        .pcOut          (pcOut),
        .linkAddrOut    (linkAddrOut),
        .haltOut        (haltOut),
        .retireCountOut (retireCountOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction-level model state
    logic [15:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_instr;

    typedef struct {
        string       name;
        logic [15:0] start_pc;
        logic [2:0]  sel;
        logic        lt;
        logic        eq;
        logic [15:0] imm;
        logic [15:0] base;
        logic [15:0] exp_pc;
        logic [15:0] exp_link;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Deterministic program image; opcode never equals 11111
    function automatic logic [31:0] word_at(input logic [15:0] pc);
        logic [31:0] p;
        p = 32'(pc);
        return {5'(p % 32'd31), 27'(p * 32'd2654435761)};
    endfunction

    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [2:0] sel,
                                             input logic lt, input logic eq,
                                             input logic [15:0] imm, input logic [15:0] base);
        logic [15:0] seq;
        logic [15:0] rel;
        seq = 16'((32'(pc) + 32'd1) % 32'd65536);
        rel = 16'((32'(pc) + 32'(imm)) % 32'd65536);
        if (sel == 3'd1) return lt ? rel : seq;
        if (sel == 3'd2) return eq ? rel : seq;
        if (sel == 3'd3) return rel;
        if (sel == 3'd4) return 16'((32'(base) + 32'(imm)) % 32'd65536);
        return seq;
    endfunction

    task automatic model_reset();
        m_pc    = 16'd0;
        m_count = 32'd0;
        m_instr = 32'd0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   32'(imemReqOut), 32'd0);
        chk({tag, "_pc"},    32'(pcOut), 32'd0);
        chk({tag, "_instr"}, instrOut, 32'd0);
        chk({tag, "_opc"},   32'(opcodeOut), 32'd0);
        chk({tag, "_valid"}, 32'(instrValidOut), 32'd0);
        chk({tag, "_halt"},  32'(haltOut), 32'd0);
        chk({tag, "_cnt"},   retireCountOut, 32'd0);
        chk({tag, "_link"},  32'(linkAddrOut), 32'd1);
    endtask

    // One full instruction: wait cycles, the fetch-completion cycle and the EXEC cycle
    task automatic run_instr(input int waits, input logic [31:0] word, input logic [2:0] sel,
                             input logic lt, input logic eq, input logic [15:0] imm,
                             input logic [15:0] base, output logic [15:0] link_seen);
        for (int w = 0; w < waits; w++) begin
            imemValidIn = 1'b0;
            imemDataIn  = $urandom;
            addrSelIn   = 3'($urandom);
            step();
            chk("wait_req", 32'(imemReqOut), 32'd1);
            chk("wait_addr", 32'(imemAddrOut), 32'(m_pc));
            chk("wait_instr", instrOut, m_instr);
            chk("wait_valid", 32'(instrValidOut), 32'd0);
        end
        imemValidIn = 1'b1;
        imemDataIn  = word;
        addrSelIn   = 3'($urandom);
        immIn       = 16'($urandom);
        step();
        m_instr = word;
        chk("exec_valid", 32'(instrValidOut), 32'd1);
        chk("exec_instr", instrOut, word);
        chk("exec_opc", 32'(opcodeOut), 32'(word[31:27]));
        chk("exec_pc", 32'(pcOut), 32'(m_pc));
        chk("exec_link", 32'(linkAddrOut), 32'(16'(32'(m_pc) + 32'd1)));
        chk("exec_req", 32'(imemReqOut), 32'd0);
        chk("exec_cnt", retireCountOut, m_count);
        link_seen   = linkAddrOut;
        imemValidIn = 1'($urandom);
        imemDataIn  = $urandom;
        addrSelIn   = sel;
        ltFlagIn    = lt;
        eqFlagIn    = eq;
        immIn       = imm;
        jalrBaseIn  = base;
        step();
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        if (word[31:27] == 5'b11111) begin
            chk("halt_flag", 32'(haltOut), 32'd1);
            chk("halt_req", 32'(imemReqOut), 32'd0);
        end else begin
            m_pc = ref_next(m_pc, sel, lt, eq, imm, base);
            chk("next_req", 32'(imemReqOut), 32'd1);
            chk("next_addr", 32'(imemAddrOut), 32'(m_pc));
            chk("next_halt", 32'(haltOut), 32'd0);
        end
        chk("next_valid", 32'(instrValidOut), 32'd0);
        chk("next_pc", 32'(pcOut), 32'(m_pc));
        chk("next_cnt", retireCountOut, m_count);
        imemValidIn = 1'b0;
    endtask

    initial begin
        logic [15:0] link;
        logic [15:0] frozen_pc;

        vecs[0] = '{"blt_taken",    16'd10,     3'b001, 1'b1, 1'b0, 16'hFFFC, 16'h0000, 16'd6,  16'd11};
        vecs[1] = '{"blt_not_taken",16'd10,     3'b001, 1'b0, 1'b1, 16'hFFFC, 16'h0000, 16'd11, 16'd11};
        vecs[2] = '{"beq_not_taken",16'd10,     3'b010, 1'b1, 1'b0, 16'hFFFC, 16'h0000, 16'd11, 16'd11};
        vecs[3] = '{"beq_taken",    16'd10,     3'b010, 1'b0, 1'b1, 16'hFFFC, 16'h0000, 16'd6,  16'd11};
        vecs[4] = '{"jal",          16'd10,     3'b011, 1'b0, 1'b0, 16'hFFFC, 16'h0000, 16'd6,  16'd11};
        vecs[5] = '{"jalr",         16'd10,     3'b100, 1'b0, 1'b0, 16'd3,    16'h0020, 16'h0023, 16'd11};
        vecs[6] = '{"seq_wrap",     16'hFFFF,   3'b000, 1'b1, 1'b1, 16'd5,    16'h1234, 16'h0000, 16'h0000};
        vecs[7] = '{"jalr_wrap",    16'h0100,   3'b100, 1'b1, 1'b1, 16'd3,    16'hFFFE, 16'h0001, 16'h0101};
        vecs[8] = '{"sel_101",      16'd10,     3'b101, 1'b1, 1'b1, 16'hFFFC, 16'h0040, 16'd11, 16'd11};
        vecs[9] = '{"sel_111",      16'd10,     3'b111, 1'b1, 1'b1, 16'hFFFC, 16'h0040, 16'd11, 16'd11};

        rst_n       = 1'b0;
        imemValidIn = 1'b0;
        imemDataIn  = 32'd0;
        addrSelIn   = 3'd0;
        ltFlagIn    = 1'b0;
        eqFlagIn    = 1'b0;
        immIn       = 16'd0;
        jalrBaseIn  = 16'd0;
        model_reset();

        // Reset and the single IDLE cycle
        step();
        step();
        chk_reset_values("rst");
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(imemReqOut), 32'd0);
        step();
        chk("first_req", 32'(imemReqOut), 32'd1);
        chk("first_addr", 32'(imemAddrOut), 32'd0);
        chk("first_valid", 32'(instrValidOut), 32'd0);
        chk("first_cnt", retireCountOut, 32'd0);

        // Sequential, zero wait states
        for (int i = 0; i < 3; i++) run_instr(0, word_at(m_pc), 3'b000, 1'b1, 1'b1, 16'd7, 16'd9, link);
        chk("seq_pc3", 32'(pcOut), 32'd3);
        chk("seq_cnt3", retireCountOut, 32'd3);

        // Memory wait states
        run_instr(3, word_at(m_pc), 3'b000, 1'b0, 1'b0, 16'd0, 16'd0, link);

        // Directed branch vectors
        for (int i = 0; i < 10; i++) begin
            run_instr(0, word_at(m_pc), 3'b100, 1'b0, 1'b0, 16'd0, vecs[i].start_pc, link);
            run_instr(i % 2, word_at(m_pc), vecs[i].sel, vecs[i].lt, vecs[i].eq,
                      vecs[i].imm, vecs[i].base, link);
            chk({vecs[i].name, "_pc"}, 32'(pcOut), 32'(vecs[i].exp_pc));
            chk({vecs[i].name, "_link"}, 32'(link), 32'(vecs[i].exp_link));
        end

        // Random instruction stream
        for (int i = 0; i < 60; i++) begin
            run_instr(int'($urandom_range(0, 2)), word_at(m_pc), 3'($urandom_range(0, 7)),
                      1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), link);
        end

        // Halt: sticky, frozen, ignores memory
        frozen_pc = m_pc;
        run_instr(1, {5'b11111, 27'h0ABCDEF}, 3'b011, 1'b1, 1'b1, 16'd50, 16'd60, link);
        for (int i = 0; i < 4; i++) begin
            imemValidIn = 1'b1;
            imemDataIn  = $urandom;
            addrSelIn   = 3'b011;
            immIn       = 16'd9;
            step();
            chk("halt_sticky", 32'(haltOut), 32'd1);
            chk("halt_noreq", 32'(imemReqOut), 32'd0);
            chk("halt_novalid", 32'(instrValidOut), 32'd0);
            chk("halt_pc", 32'(pcOut), 32'(frozen_pc));
            chk("halt_instr", instrOut, m_instr);
            chk("halt_cnt", retireCountOut, m_count);
        end

        // Asynchronous reset during HALT
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_values("rst_halt");
        step();
        rst_n = 1'b1;
        imemValidIn = 1'b0;
        step();
        chk("rehalt_req", 32'(imemReqOut), 32'd1);
        chk("rehalt_addr", 32'(imemAddrOut), 32'd0);
        run_instr(0, word_at(m_pc), 3'b011, 1'b0, 1'b0, 16'd20, 16'd0, link);
        chk("post_halt_pc", 32'(pcOut), 32'd20);

        // Reset during a FETCH wait, with a stale response arriving around reset
        imemValidIn = 1'b0;
        step();
        step();
        imemValidIn = 1'b1;
        imemDataIn  = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_values("rst_fetch");
        step();
        chk_reset_values("rst_fetch_hold");
        rst_n = 1'b1;
        step();
        chk("stale_req", 32'(imemReqOut), 32'd1);
        chk("stale_addr", 32'(imemAddrOut), 32'd0);
        chk("stale_instr", instrOut, 32'd0);
        chk("stale_valid", 32'(instrValidOut), 32'd0);
        run_instr(0, word_at(m_pc), 3'b000, 1'b0, 1'b0, 16'd0, 16'd0, link);
        chk("after_stale_pc", 32'(pcOut), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
